db_mcu_arbiter: RTL and testbench
=================================

DB_MCU_ARBITER -- requirements
Module: db_mcu_arbiter

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- valid  in  1  debugger command strobe, one cycle
- pause, resume, reg_rd, reg_wr, mem_rd, mem_wr  in  1 each  command opcode, one-hot, sampled with valid
- mem_rw_byte  in  1  1 = byte access, 0 = word access
- addr  in  32  register index [4:0] or memory byte address
- d_in  in  32  write data
- mcu_busy  out  1  command in progress
- d_rd  out  32  last read result
- error  out  1  one-cycle failure pulse
- cpu_pause  out  1  halt request to CPU fetch
- cpu_idle  in  1  CPU pipeline drained
- cpu_mem_req  in  1  CPU memory request
- cpu_mem_gnt  out  1  CPU owns memory bus this cycle
- dbg_mem_req  out  1  debugger memory request to bus mux
- mem_we  out  1  debugger write enable
- mem_be  out  4  debugger byte enables
- mem_addr  out  32  debugger address, word-aligned
- mem_wdata  out  32  debugger write data
- mem_ack  in  1  memory access complete
- mem_rdata  in  32  memory read data
- rf_addr  out  5  register-file debug port index
- rf_wr  out  1  register-file write strobe
- rf_wdata  out  32  register-file write data
- rf_rdata  in  32  register-file read data, registered, valid one cycle after rf_addr

Function
REQ-002 SHALL implement states RUN, HALTING, HALTED, REG, MEM_WAIT, MEM.
REQ-003 SHALL accept a command only when valid=1 and mcu_busy=0; valid while busy SHALL be ignored without error.
REQ-004 SHALL pulse error one cycle, state unchanged, on accepted command with zero or more than one opcode bit set.
REQ-005 pause in RUN: cpu_pause=1 next cycle, go HALTING; HALTING->HALTED on first cycle cpu_idle=1.
REQ-006 HALTING SHALL count cycles in an 8-bit counter; at 255 without cpu_idle: error pulse, cpu_pause=0, return RUN.
REQ-007 pause in HALTED SHALL be a no-op without error; resume in HALTED SHALL clear cpu_pause next cycle and go RUN; resume in RUN SHALL be a no-op.
REQ-008 reg_rd/reg_wr SHALL be legal only in HALTED; in RUN: error pulse, no register access.
REQ-009 reg_wr: rf_addr=addr[4:0], rf_wdata=d_in, rf_wr one cycle; rf_wr suppressed when addr[4:0]=0 (x0); return HALTED.
REQ-010 reg_rd: rf_addr driven in REG; d_rd<=rf_rdata the following cycle; mcu_busy high exactly 2 cycles.
REQ-011 mem_rd/mem_wr legal in RUN and HALTED; word access with addr[1:0]!=0: error pulse, no bus access.
REQ-012 MEM_WAIT SHALL wait for a cycle with cpu_mem_req=0 (immediate in HALTED), then assert dbg_mem_req; an in-flight CPU access is never preempted.
REQ-013 cpu_mem_gnt SHALL be 1 exactly when dbg_mem_req=0 and state is not HALTING/HALTED; cpu_mem_gnt and dbg_mem_req SHALL never both be 1.
REQ-014 In MEM, dbg_mem_req, mem_addr={addr[31:2],2'b00}, mem_we, mem_be, mem_wdata SHALL hold stable until mem_ack.
REQ-015 Byte write: mem_be=1<<addr[1:0], mem_wdata=d_in[7:0] replicated 4x; word: mem_be=4'hF, mem_wdata=d_in.
REQ-016 Byte read: d_rd<=zero-extended lane addr[1:0] of mem_rdata on ack; word read: d_rd<=mem_rdata.
REQ-017 MEM_WAIT+MEM SHALL share an 8-bit timeout; at 255 cycles without mem_ack: error pulse, dbg_mem_req=0, return to prior RUN/HALTED state.
REQ-018 After memory op SHALL return to the state held before the command (RUN or HALTED).
REQ-019 mcu_busy SHALL be 1 in HALTING, REG, MEM_WAIT, MEM, else 0; it rises the cycle after acceptance.
REQ-020 d_rd SHALL hold its value until the next successful read completes; failed ops leave d_rd unchanged.

Reset
REQ-021 rst_n=0 SHALL immediately force state RUN, all outputs 0, d_rd=0, counters 0, including mid-operation (dbg_mem_req drops asynchronously).
REQ-022 First command SHALL be accepted on the first clk edge with rst_n=1.

Verification
REQ-023 pause, cpu_idle rises 3 cycles later -> cpu_pause=1, mcu_busy 1 for 4 cycles, then HALTED; resume -> cpu_pause=0 next cycle.
REQ-024 halted, reg_wr addr=5 d_in=0xDEADBEEF, then reg_rd addr=5 with model RF -> d_rd=0xDEADBEEF; reg_wr addr=0 -> rf_wr never asserted.
REQ-025 running, cpu_mem_req high 10 cycles, mem_wr byte addr=0x1003 d_in=0xA5 -> dbg_mem_req waits until cpu_mem_req=0, mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xA5A5A5A5, no overlap with cpu_mem_gnt.
REQ-026 reg_rd in RUN, word mem_rd addr=0x2, opcode pause|resume -> each gives single error pulse, no bus/RF activity.
REQ-027 pause with cpu_idle held 0 -> error pulse at cycle 255, cpu_pause=0; mem_rd with mem_ack held 0 -> error, dbg_mem_req released.
REQ-028 rst_n asserted during MEM -> all outputs 0 without clock edge; post-reset mem_rd completes normally.

Source files
------------

// File: rtl/db_mcu_arbiter.sv
// ---------------------------------------------------------------------------
// db_mcu_arbiter
//
// Purpose:
//   Debug-module command engine sitting between a debugger front end and a
//   small MCU. It halts/resumes the CPU, reads and writes the register file
//   through its debug port, and performs byte/word memory accesses by
//   borrowing the memory bus from the CPU without cutting off a CPU access
//   that is already in flight.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   valid + opcode bits     one-cycle command strobe; pause, resume, reg_rd,
//                           reg_wr, mem_rd, mem_wr are expected one-hot
//   mem_rw_byte, addr, d_in command operands
//   mcu_busy, d_rd, error   command status, last read result, failure pulse
//   cpu_pause, cpu_idle     halt handshake with the CPU pipeline
//   cpu_mem_req/gnt         CPU side of the memory bus arbitration
//   dbg_mem_req, mem_*      debugger memory master port
//   rf_*                    register-file debug port (registered read data)
// ---------------------------------------------------------------------------
module db_mcu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic        pause,
   input  logic        resume,
   input  logic        reg_rd,
   input  logic        reg_wr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic        mem_rw_byte,
   input  logic [31:0] addr,
   input  logic [31:0] d_in,
   output logic        mcu_busy,
   output logic [31:0] d_rd,
   output logic        error,
   output logic        cpu_pause,
   input  logic        cpu_idle,
   input  logic        cpu_mem_req,
   output logic        cpu_mem_gnt,
   output logic        dbg_mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [4:0]  rf_addr,
   output logic        rf_wr,
   output logic [31:0] rf_wdata,
   input  logic [31:0] rf_rdata
);

   typedef enum logic [2:0] {
      RUN      = 3'd0,
      HALTING  = 3'd1,
      HALTED   = 3'd2,
      REG      = 3'd3,
      MEM_WAIT = 3'd4,
      MEM      = 3'd5
   } state_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        ret_halted, ret_halted_n;
   logic        op_wr, op_wr_n;
   logic        op_byte, op_byte_n;
   logic [1:0]  lane, lane_n;
   logic        reg_phase, reg_phase_n;

   logic        cpu_pause_n, error_n, dbg_mem_req_n, mem_we_n, rf_wr_n;
   logic [31:0] d_rd_n, mem_addr_n, mem_wdata_n, rf_wdata_n;
   logic [3:0]  mem_be_n;
   logic [4:0]  rf_addr_n;

   logic [5:0]  ops;
   logic        one_hot;
   logic        accept;

   // Command decode. A command is only looked at when the engine is idle;
   // anything strobed while busy simply falls on the floor.
   assign ops      = {pause, resume, reg_rd, reg_wr, mem_rd, mem_wr};
   assign one_hot  = (ops != 6'd0) && ((ops & (ops - 6'd1)) == 6'd0);
   assign mcu_busy = (state == HALTING) || (state == REG) ||
                     (state == MEM_WAIT) || (state == MEM);
   assign accept   = valid && !mcu_busy;

   // The CPU owns the bus whenever the debugger is not requesting it and the
   // CPU is not being held. Because dbg_mem_req is itself a register, the
   // two grants can never overlap. rst_n gates it so the grant is low while
   // reset is applied, like every other output.
   assign cpu_mem_gnt = rst_n && !dbg_mem_req &&
                        (state != HALTING) && (state != HALTED);

   // Next-state and next-output logic. Every register holds by default;
   // error and rf_wr are single-cycle strobes and default low instead.
   // Memory accesses latch address/data at acceptance but only raise
   // dbg_mem_req, mem_we and mem_be once the bus is actually free, and all
   // of those stay frozen in MEM until the ack or the timeout.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      ret_halted_n  = ret_halted;
      op_wr_n       = op_wr;
      op_byte_n     = op_byte;
      lane_n        = lane;
      reg_phase_n   = reg_phase;
      cpu_pause_n   = cpu_pause;
      error_n       = 1'b0;
      d_rd_n        = d_rd;
      dbg_mem_req_n = dbg_mem_req;
      mem_we_n      = mem_we;
      mem_be_n      = mem_be;
      mem_addr_n    = mem_addr;
      mem_wdata_n   = mem_wdata;
      rf_addr_n     = rf_addr;
      rf_wr_n       = 1'b0;
      rf_wdata_n    = rf_wdata;

      case (state)
         RUN, HALTED: begin
            if (accept) begin
               if (!one_hot) begin
                  error_n = 1'b1;
               end else if (pause) begin
                  if (state == RUN) begin
                     cpu_pause_n = 1'b1;
                     cnt_n       = 8'd0;
                     state_n     = HALTING;
                  end
               end else if (resume) begin
                  if (state == HALTED) begin
                     cpu_pause_n = 1'b0;
                     state_n     = RUN;
                  end
               end else if (reg_rd || reg_wr) begin
                  if (state == RUN) begin
                     error_n = 1'b1;
                  end else begin
                     rf_addr_n   = addr[4:0];
                     op_wr_n     = reg_wr;
                     reg_phase_n = 1'b0;
                     if (reg_wr) begin
                        rf_wdata_n = d_in;
                        rf_wr_n    = (addr[4:0] != 5'd0);
                     end
                     state_n = REG;
                  end
               end else begin
                  if (!mem_rw_byte && (addr[1:0] != 2'b00)) begin
                     error_n = 1'b1;
                  end else begin
                     ret_halted_n = (state == HALTED);
                     op_wr_n      = mem_wr;
                     op_byte_n    = mem_rw_byte;
                     lane_n       = addr[1:0];
                     mem_addr_n   = {addr[31:2], 2'b00};
                     mem_wdata_n  = mem_rw_byte ? {4{d_in[7:0]}} : d_in;
                     cnt_n        = 8'd0;
                     state_n      = MEM_WAIT;
                  end
               end
            end
         end

         HALTING: begin
            if (cpu_idle) begin
               state_n = HALTED;
            end else if (cnt == 8'd255) begin
               error_n     = 1'b1;
               cpu_pause_n = 1'b0;
               state_n     = RUN;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end

         REG: begin
            // Writes finish after their single strobe cycle. Reads need one
            // cycle for the RF to register rf_addr and one to capture it.
            if (op_wr) begin
               state_n = HALTED;
            end else if (!reg_phase) begin
               reg_phase_n = 1'b1;
            end else begin
               d_rd_n  = rf_rdata;
               state_n = HALTED;
            end
         end

         MEM_WAIT: begin
            // While the CPU runs, only take the bus on a cycle where it is
            // not requesting; a halted CPU cannot be mid-access.
            if (cnt == 8'd255) begin
               error_n = 1'b1;
               state_n = ret_halted ? HALTED : RUN;
            end else begin
               cnt_n = cnt + 8'd1;
               if (ret_halted || !cpu_mem_req) begin
                  dbg_mem_req_n = 1'b1;
                  mem_we_n      = op_wr;
                  mem_be_n      = op_byte ? (4'b0001 << lane) : 4'hF;
                  state_n       = MEM;
               end
            end
         end

         MEM: begin
            if (mem_ack) begin
               if (!op_wr) begin
                  d_rd_n = op_byte ? {24'd0, mem_rdata[{lane, 3'b000} +: 8]}
                                   : mem_rdata;
               end
               dbg_mem_req_n = 1'b0;
               mem_we_n      = 1'b0;
               mem_be_n      = 4'h0;
               state_n       = ret_halted ? HALTED : RUN;
            end else if (cnt == 8'd255) begin
               error_n       = 1'b1;
               dbg_mem_req_n = 1'b0;
               mem_we_n      = 1'b0;
               mem_be_n      = 4'h0;
               state_n       = ret_halted ? HALTED : RUN;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end

         default: begin
            state_n = RUN;
         end
      endcase
   end

   // State and output registers. Reset is asynchronous so a debugger reset
   // drops the bus request immediately, even in the middle of an access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         cnt         <= 8'd0;
         ret_halted  <= 1'b0;
         op_wr       <= 1'b0;
         op_byte     <= 1'b0;
         lane        <= 2'b00;
         reg_phase   <= 1'b0;
         cpu_pause   <= 1'b0;
         error       <= 1'b0;
         d_rd        <= 32'd0;
         dbg_mem_req <= 1'b0;
         mem_we      <= 1'b0;
         mem_be      <= 4'h0;
         mem_addr    <= 32'd0;
         mem_wdata   <= 32'd0;
         rf_addr     <= 5'd0;
         rf_wr       <= 1'b0;
         rf_wdata    <= 32'd0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         ret_halted  <= ret_halted_n;
         op_wr       <= op_wr_n;
         op_byte     <= op_byte_n;
         lane        <= lane_n;
         reg_phase   <= reg_phase_n;
         cpu_pause   <= cpu_pause_n;
         error       <= error_n;
         d_rd        <= d_rd_n;
         dbg_mem_req <= dbg_mem_req_n;
         mem_we      <= mem_we_n;
         mem_be      <= mem_be_n;
         mem_addr    <= mem_addr_n;
         mem_wdata   <= mem_wdata_n;
         rf_addr     <= rf_addr_n;
         rf_wr       <= rf_wr_n;
         rf_wdata    <= rf_wdata_n;
      end
   end

endmodule

// File: tb/tb_db_mcu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_db_mcu_arbiter
//
// Purpose:
//   Directed self-checking bench for db_mcu_arbiter. A register-file model
//   answers the debug port; memory transactions and read results are queued
//   as expectations when a command is issued and popped when the DUT acts.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_db_mcu_arbiter;

   logic        clk, rst_n, valid;
   logic        pause, resume, reg_rd, reg_wr, mem_rd, mem_wr;
   logic        mem_rw_byte;
   logic [31:0] addr, d_in;
   logic        mcu_busy;
   logic [31:0] d_rd;
   logic        error, cpu_pause, cpu_idle, cpu_mem_req, cpu_mem_gnt;
   logic        dbg_mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [4:0]  rf_addr;
   logic        rf_wr;
   logic [31:0] rf_wdata, rf_rdata;

   localparam logic [5:0] OP_PAUSE  = 6'b100000;
   localparam logic [5:0] OP_RESUME = 6'b010000;
   localparam logic [5:0] OP_REG_RD = 6'b001000;
   localparam logic [5:0] OP_REG_WR = 6'b000100;
   localparam logic [5:0] OP_MEM_RD = 6'b000010;
   localparam logic [5:0] OP_MEM_WR = 6'b000001;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_exp_t;

   bus_exp_t    exp_bus[$];
   logic [31:0] exp_rd[$];

   int n_checks = 0;
   int n_errors = 0;
   int err_pulses = 0;
   int overlap_cnt = 0;
   int x0_wr_cnt = 0;
   int bus_cnt = 0;
   logic dbg_prev = 1'b0;
   logic [31:0] rf_mem [32];

   db_mcu_arbiter dut (
      .clk(clk), .rst_n(rst_n), .valid(valid),
      .pause(pause), .resume(resume), .reg_rd(reg_rd), .reg_wr(reg_wr),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rw_byte(mem_rw_byte),
      .addr(addr), .d_in(d_in), .mcu_busy(mcu_busy), .d_rd(d_rd),
      .error(error), .cpu_pause(cpu_pause), .cpu_idle(cpu_idle),
      .cpu_mem_req(cpu_mem_req), .cpu_mem_gnt(cpu_mem_gnt),
      .dbg_mem_req(dbg_mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .rf_addr(rf_addr), .rf_wr(rf_wr),
      .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register-file model: x0 reads as zero, read data is registered so it
   // appears one cycle after rf_addr.
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
   end

   always @(posedge clk) begin
      if (rf_wr && rf_addr != 5'd0) rf_mem[rf_addr] <= rf_wdata;
      rf_rdata <= (rf_addr == 5'd0) ? 32'd0 : rf_mem[rf_addr];
   end

   // Passive monitors: error pulses, bus overlap, x0 writes, bus requests.
   always @(negedge clk) begin
      if (error) err_pulses++;
      if (cpu_mem_gnt && dbg_mem_req) overlap_cnt++;
      if (rf_wr && rf_addr == 5'd0) x0_wr_cnt++;
      if (dbg_mem_req && !dbg_prev) bus_cnt++;
      dbg_prev = dbg_mem_req;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one command for a single cycle, starting just after a falling edge.
   task automatic applyStimulus(input logic [5:0] op, input logic byt,
                                input logic [31:0] a, input logic [31:0] d);
      valid = 1'b1;
      {pause, resume, reg_rd, reg_wr, mem_rd, mem_wr} = op;
      mem_rw_byte = byt;
      addr = a;
      d_in = d;
      @(negedge clk);
      valid = 1'b0;
      {pause, resume, reg_rd, reg_wr, mem_rd, mem_wr} = 6'd0;
   endtask

   task automatic settleCycles(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Issue a memory command and queue what the bus and d_rd should show.
   task automatic issueMem(input logic wr, input logic byt, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rdata);
      bus_exp_t e;
      logic [31:0] sh;
      e.a     = {a[31:2], 2'b00};
      e.be    = byt ? (4'b0001 << a[1:0]) : 4'b1111;
      e.we    = wr;
      e.wdata = byt ? {d[7:0], d[7:0], d[7:0], d[7:0]} : d;
      exp_bus.push_back(e);
      if (!wr) begin
         sh = rdata >> (8 * a[1:0]);
         exp_rd.push_back(byt ? {24'd0, sh[7:0]} : rdata);
      end
      applyStimulus(wr ? OP_MEM_WR : OP_MEM_RD, byt, a, d);
   endtask

   // Wait for the debugger bus request, check it, hold it, then acknowledge.
   task automatic serveMem(input string tag, input logic [31:0] rdata);
      bus_exp_t e;
      int waited = 0;
      while (!dbg_mem_req && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      checkOutput({tag, "_req_seen"}, {31'd0, dbg_mem_req}, 32'd1);
      e = exp_bus.pop_front();
      checkOutput({tag, "_addr"}, mem_addr, e.a);
      checkOutput({tag, "_be"}, {28'd0, mem_be}, {28'd0, e.be});
      checkOutput({tag, "_we"}, {31'd0, mem_we}, {31'd0, e.we});
      if (e.we) checkOutput({tag, "_wdata"}, mem_wdata, e.wdata);
      @(negedge clk);
      checkOutput({tag, "_addr_hold"}, mem_addr, e.a);
      checkOutput({tag, "_req_hold"}, {31'd0, dbg_mem_req}, 32'd1);
      mem_rdata = rdata;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      checkOutput({tag, "_busy_done"}, {31'd0, mcu_busy}, 32'd0);
      checkOutput({tag, "_req_drop"}, {31'd0, dbg_mem_req}, 32'd0);
      if (!e.we) checkOutput({tag, "_d_rd"}, d_rd, exp_rd.pop_front());
   endtask

   // Count the cycles mcu_busy stays high; optionally raise cpu_idle once
   // a given number of busy cycles has been seen.
   task automatic countBusy(input int idle_at, output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (!mcu_busy) break;
         cnt++;
         if (cnt == idle_at) cpu_idle = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      int busy_cnt, e0, b0, cyc;
      logic [31:0] d_before;

      rst_n = 1'b0; valid = 1'b0;
      {pause, resume, reg_rd, reg_wr, mem_rd, mem_wr} = 6'd0;
      mem_rw_byte = 1'b0; addr = 32'd0; d_in = 32'd0;
      cpu_idle = 1'b0; cpu_mem_req = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;

      // Outputs while reset is held.
      #2;
      checkOutput("rst_busy", {31'd0, mcu_busy}, 32'd0);
      checkOutput("rst_pause", {31'd0, cpu_pause}, 32'd0);
      checkOutput("rst_gnt", {31'd0, cpu_mem_gnt}, 32'd0);
      checkOutput("rst_dbg_req", {31'd0, dbg_mem_req}, 32'd0);
      checkOutput("rst_d_rd", d_rd, 32'd0);
      repeat (2) @(negedge clk);

      // Release reset together with a pause so the first edge accepts it.
      rst_n = 1'b1;
      #1;
      checkOutput("post_rst_gnt", {31'd0, cpu_mem_gnt}, 32'd1);
      applyStimulus(OP_PAUSE, 1'b0, 32'd0, 32'd0);
      checkOutput("pause_cpu_pause", {31'd0, cpu_pause}, 32'd1);
      countBusy(4, busy_cnt);
      checkOutput("halting_busy_cycles", busy_cnt, 32'd4);
      checkOutput("halted_pause", {31'd0, cpu_pause}, 32'd1);
      checkOutput("halted_gnt", {31'd0, cpu_mem_gnt}, 32'd0);

      // Pause while halted is a silent no-op.
      settleCycles(0);
      e0 = err_pulses;
      applyStimulus(OP_PAUSE, 1'b0, 32'd0, 32'd0);
      settleCycles(2);
      checkOutput("halted_pause_noerr", err_pulses, e0);
      checkOutput("halted_pause_busy", {31'd0, mcu_busy}, 32'd0);

      // Register write then read back through the RF model.
      applyStimulus(OP_REG_WR, 1'b0, 32'd5, 32'hDEADBEEF);
      checkOutput("reg_wr_strobe", {31'd0, rf_wr}, 32'd1);
      checkOutput("reg_wr_addr", {27'd0, rf_addr}, 32'd5);
      @(negedge clk);
      exp_rd.push_back(32'hDEADBEEF);
      applyStimulus(OP_REG_RD, 1'b0, 32'd5, 32'd0);
      countBusy(0, busy_cnt);
      checkOutput("reg_rd_busy_cycles", busy_cnt, 32'd2);
      checkOutput("reg_rd_d_rd", d_rd, exp_rd.pop_front());

      // Writes to x0 must never strobe the RF; x0 reads back zero.
      applyStimulus(OP_REG_WR, 1'b0, 32'd0, 32'h00001234);
      settleCycles(2);
      checkOutput("x0_no_write", x0_wr_cnt, 32'd0);
      exp_rd.push_back(32'd0);
      applyStimulus(OP_REG_RD, 1'b0, 32'd0, 32'd0);
      countBusy(0, busy_cnt);
      checkOutput("x0_rd_d_rd", d_rd, exp_rd.pop_front());

      // Memory write while halted goes straight through and stays halted.
      cpu_mem_req = 1'b1;
      issueMem(1'b1, 1'b0, 32'h00000080, 32'h12345678, 32'd0);
      serveMem("halt_wr", 32'd0);
      cpu_mem_req = 1'b0;
      checkOutput("halt_wr_still_paused", {31'd0, cpu_pause}, 32'd1);
      checkOutput("halt_wr_gnt", {31'd0, cpu_mem_gnt}, 32'd0);

      // Resume releases the CPU the next cycle; resume in RUN is a no-op.
      applyStimulus(OP_RESUME, 1'b0, 32'd0, 32'd0);
      checkOutput("resume_pause", {31'd0, cpu_pause}, 32'd0);
      checkOutput("resume_gnt", {31'd0, cpu_mem_gnt}, 32'd1);
      settleCycles(0);
      e0 = err_pulses;
      applyStimulus(OP_RESUME, 1'b0, 32'd0, 32'd0);
      settleCycles(2);
      checkOutput("run_resume_noerr", err_pulses, e0);

      // Byte write held off by a busy CPU for 10 cycles.
      cpu_mem_req = 1'b1;
      b0 = bus_cnt;
      issueMem(1'b1, 1'b1, 32'h00001003, 32'h000000A5, 32'd0);
      repeat (9) @(negedge clk);
      checkOutput("wait_no_dbg_req", {31'd0, dbg_mem_req}, 32'd0);
      checkOutput("wait_no_bus_start", bus_cnt, b0);
      cpu_mem_req = 1'b0;
      serveMem("byte_wr", 32'd0);

      // Word and byte reads while running.
      issueMem(1'b0, 1'b0, 32'h00002000, 32'd0, 32'h11223344);
      serveMem("word_rd", 32'h11223344);
      issueMem(1'b0, 1'b1, 32'h00002002, 32'd0, 32'h11223344);
      serveMem("byte_rd", 32'h11223344);

      // Illegal commands: each one a single error pulse, no side effects.
      settleCycles(0);
      e0 = err_pulses; b0 = bus_cnt;
      applyStimulus(OP_REG_RD, 1'b0, 32'd5, 32'd0);
      settleCycles(2);
      checkOutput("run_reg_rd_err", err_pulses, e0 + 1);
      applyStimulus(OP_MEM_RD, 1'b0, 32'h00000002, 32'd0);
      settleCycles(2);
      checkOutput("misaligned_err", err_pulses, e0 + 2);
      applyStimulus(OP_PAUSE | OP_RESUME, 1'b0, 32'd0, 32'd0);
      settleCycles(2);
      checkOutput("multi_op_err", err_pulses, e0 + 3);
      checkOutput("multi_op_no_pause", {31'd0, cpu_pause}, 32'd0);
      applyStimulus(6'd0, 1'b0, 32'd0, 32'd0);
      settleCycles(2);
      checkOutput("zero_op_err", err_pulses, e0 + 4);
      checkOutput("illegal_no_bus", bus_cnt, b0);
      checkOutput("illegal_d_rd", d_rd, 32'h00000022);

      // Halt timeout: cpu_idle never rises. A command sent meanwhile is
      // ignored because the engine is busy.
      cpu_idle = 1'b0;
      e0 = err_pulses; b0 = bus_cnt;
      applyStimulus(OP_PAUSE, 1'b0, 32'd0, 32'd0);
      cyc = 1;
      applyStimulus(OP_MEM_RD, 1'b0, 32'h00000100, 32'd0);
      cyc++;
      while (!error && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("halt_timeout_pulse", {31'd0, error}, 32'd1);
      checkOutput("halt_timeout_window", (cyc >= 250 && cyc <= 260) ? 32'd1 : 32'd0, 32'd1);
      checkOutput("halt_timeout_pause", {31'd0, cpu_pause}, 32'd0);
      checkOutput("halt_timeout_busy", {31'd0, mcu_busy}, 32'd0);
      settleCycles(2);
      checkOutput("halt_timeout_one_err", err_pulses, e0 + 1);
      checkOutput("busy_cmd_ignored", bus_cnt, b0);

      // Memory timeout: mem_ack never comes.
      e0 = err_pulses; b0 = bus_cnt;
      d_before = d_rd;
      applyStimulus(OP_MEM_RD, 1'b0, 32'h00003000, 32'd0);
      cyc = 0;
      while (mcu_busy && cyc < 600) begin
         @(negedge clk);
         cyc++;
      end
      settleCycles(1);
      checkOutput("mem_timeout_busy", {31'd0, mcu_busy}, 32'd0);
      checkOutput("mem_timeout_err", err_pulses, e0 + 1);
      checkOutput("mem_timeout_req", {31'd0, dbg_mem_req}, 32'd0);
      checkOutput("mem_timeout_bus_used", bus_cnt, b0 + 1);
      checkOutput("mem_timeout_d_rd", d_rd, d_before);

      // Asynchronous reset in the middle of a memory access.
      issueMem(1'b0, 1'b0, 32'h00004000, 32'd0, 32'h0BADF00D);
      cyc = 0;
      while (!dbg_mem_req && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("mid_rst_req_before", {31'd0, dbg_mem_req}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_req", {31'd0, dbg_mem_req}, 32'd0);
      checkOutput("mid_rst_busy", {31'd0, mcu_busy}, 32'd0);
      checkOutput("mid_rst_addr", mem_addr, 32'd0);
      checkOutput("mid_rst_d_rd", d_rd, 32'd0);
      checkOutput("mid_rst_gnt", {31'd0, cpu_mem_gnt}, 32'd0);
      exp_bus.delete();
      exp_rd.delete();
      @(negedge clk);
      rst_n = 1'b1;
      issueMem(1'b0, 1'b0, 32'h00004004, 32'd0, 32'hCAFEF00D);
      serveMem("post_rst_rd", 32'hCAFEF00D);

      settleCycles(1);
      checkOutput("no_grant_overlap", overlap_cnt, 32'd0);
      checkOutput("no_x0_write", x0_wr_cnt, 32'd0);
      checkOutput("scoreboard_empty", exp_bus.size() + exp_rd.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Backstop so the run always ends even if a wait above misbehaves.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed no end expected end");
      $fatal(1, "[TB] global timeout");
   end

endmodule
